// File: rtl/culsans_tohost_monitor_if.sv
// Snooped AXI write-path signals (AW and W channels) seen by the tohost monitor.
interface culsans_tohost_monitor_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  logic                   aw_valid_i;
  logic                   aw_ready_i;
  logic [AddrWidth-1:0]   aw_addr_i;
  logic                   w_valid_i;
  logic                   w_ready_i;
  logic [DataWidth-1:0]   w_data_i;
  logic [DataWidth/8-1:0] w_strb_i;
  logic                   w_last_i;

  modport master (
    output aw_valid_i, aw_ready_i, aw_addr_i,
    output w_valid_i, w_ready_i, w_data_i, w_strb_i, w_last_i
  );

  modport slave (
    input aw_valid_i, aw_ready_i, aw_addr_i,
    input w_valid_i, w_ready_i, w_data_i, w_strb_i, w_last_i
  );
endinterface

// File: rtl/culsans_tohost_monitor.sv
// Passive HTIF tohost snooper: pairs AW matches with first W beats in order, merges into a shadow word.
// exit_o updates on the edge that pops a matching pair; never backpressures the bus (overflow drops + flags).
module culsans_tohost_monitor #(
  parameter int unsigned          AddrWidth  = 64,
  parameter int unsigned          DataWidth  = 64,
  parameter logic [63:0]          DramBase   = 64'h8000_0000,
  parameter logic [AddrWidth-1:0] TohostAddr = AddrWidth'(DramBase + 64'h1000),
  parameter int unsigned          FifoDepth  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst,
  culsans_tohost_monitor_if.slave  bus,
  output logic [31:0]              exit_o,
  output logic [15:0]              syscall_cnt_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [PtrW:0] Full = (PtrW+1)'(FifoDepth);

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] dat;
  } wbeat_t;

  logic [FifoDepth-1:0] aw_mem;
  logic [PtrW-1:0]      aw_rptr, aw_wptr;
  logic [PtrW:0]        aw_cnt;
  wbeat_t               w_mem [FifoDepth];
  logic [PtrW-1:0]      w_rptr, w_wptr;
  logic [PtrW:0]        w_cnt;

  logic        beat0;
  logic [31:0] shadow;

  logic        aw_push, aw_full, aw_wr;
  logic        w_hs, w_push, w_full, w_wr;
  logic        pop, match;
  wbeat_t      head;
  logic [31:0] merged;

  // Bits outside the tohost word and the 8-byte aligned address are irrelevant here.
  logic unused_bits;
  assign unused_bits = ^{bus.aw_addr_i[2:0], bus.w_data_i[DataWidth-1:32],
                         bus.w_strb_i[DataWidth/8-1:4]};

  assign match   = (bus.aw_addr_i[AddrWidth-1:3] == TohostAddr[AddrWidth-1:3]);
  assign pop     = (aw_cnt != '0) && (w_cnt != '0);
  assign aw_push = bus.aw_valid_i & bus.aw_ready_i;
  assign aw_full = (aw_cnt == Full);
  assign aw_wr   = aw_push & (~aw_full | pop);
  assign w_hs    = bus.w_valid_i & bus.w_ready_i;
  assign w_push  = w_hs & beat0;
  assign w_full  = (w_cnt == Full);
  assign w_wr    = w_push & (~w_full | pop);
  assign head    = w_mem[w_rptr];

  always_comb begin
    merged = shadow;
    for (int b = 0; b < 4; b++) begin
      if (head.strb[b]) merged[8*b +: 8] = head.dat[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_wr) aw_mem[aw_wptr] <= match;
    if (w_wr)  w_mem[w_wptr]   <= '{strb: bus.w_strb_i[3:0], dat: bus.w_data_i[31:0]};
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      aw_rptr       <= '0;
      aw_wptr       <= '0;
      aw_cnt        <= '0;
      w_rptr        <= '0;
      w_wptr        <= '0;
      w_cnt         <= '0;
      beat0         <= 1'b1;
      shadow        <= '0;
      exit_o        <= '0;
      syscall_cnt_o <= '0;
      overflow_o    <= 1'b0;
    end else begin
      if (aw_wr) aw_wptr <= aw_wptr + 1'b1;
      if (w_wr)  w_wptr  <= w_wptr + 1'b1;
      if (pop) begin
        aw_rptr <= aw_rptr + 1'b1;
        w_rptr  <= w_rptr + 1'b1;
      end
      aw_cnt <= aw_cnt + (PtrW+1)'(aw_wr) - (PtrW+1)'(pop);
      w_cnt  <= w_cnt + (PtrW+1)'(w_wr) - (PtrW+1)'(pop);

      // Only the first beat of each burst carries the word we care about.
      if (w_hs) beat0 <= bus.w_last_i;

      if ((aw_push & aw_full & ~pop) | (w_push & w_full & ~pop)) overflow_o <= 1'b1;

      if (pop && aw_mem[aw_rptr]) begin
        shadow <= merged;
        if (!exit_o[0]) begin
          if (merged[0]) begin
            exit_o <= merged;
          end else if (syscall_cnt_o != 16'hFFFF) begin
            syscall_cnt_o <= syscall_cnt_o + 16'd1;
          end
        end
      end
    end
  end

endmodule
